// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared IF-stage state encoding, reset PC, SRAM size and ID bus width.
package if_fetch_unit_pkg;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fs_state_e;
    localparam logic [31:0] IF_RESET_PC    = 32'h1c00_0000;
    localparam logic [1:0]  SRAM_SIZE_WORD = 2'b10;
    localparam int unsigned FS_TO_DS_W     = 64;
endpackage

// File: rtl/if_redirect_pend.sv
// if_redirect_pend: pending redirect target and single-response cancel flag; a flush
// overrides a pending branch, a branch never overrides a pending flush.
module if_redirect_pend (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_valid_i,
    input  logic [31:0] flush_target_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        track_i,
    input  logic        arm_i,
    input  logic        clear_i,
    output logic        redir_o,
    output logic [31:0] redir_target_o,
    output logic        cancel_o,
    output logic [31:0] final_target_o
);
    logic        pend_valid_q, pend_valid_d, pend_flush_q, pend_flush_d;
    logic        cancel_q, cancel_d, take;
    logic [31:0] pend_target_q, pend_target_d;

    assign redir_o        = flush_valid_i | br_taken_i;
    assign redir_target_o = flush_valid_i ? flush_target_i : br_target_i;
    assign take           = flush_valid_i | (br_taken_i & ~(pend_valid_q & pend_flush_q));
    assign final_target_o = take ? redir_target_o : pend_target_q;
    assign cancel_o       = cancel_q;

    always_comb begin
        pend_valid_d  = clear_i ? 1'b0 : pend_valid_q | (track_i & take);
        pend_flush_d  = clear_i ? 1'b0 : (track_i & take) ? flush_valid_i : pend_flush_q;
        pend_target_d = (track_i & take) ? redir_target_o : pend_target_q;
        cancel_d      = clear_i ? 1'b0 : cancel_q | (arm_i & (pend_valid_q | redir_o));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_flush_q  <= 1'b0;
            pend_target_q <= '0;
            cancel_q      <= 1'b0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_flush_q  <= pend_flush_d;
            pend_target_q <= pend_target_d;
            cancel_q      <= cancel_d;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage PC generation, instruction SRAM request and ID hand-off buffer.
// Define IF_ADEF_CHECK_EN to raise fs_ex_adef instead of fetching a misaligned PC.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        flush_valid,
    input  logic [31:0] flush_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_allow_in,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic        fs_ex_adef
);
    fs_state_e             state_q, state_d;
    logic [31:0]           pc_req_q, pc_req_d, redir_target, final_target;
    logic [FS_TO_DS_W-1:0] fs_q, fs_d;
    logic                  req_q, valid_q, adef_q, adef_d, mis, mis_d;
    logic                  redir, cancel, drop, track, arm, clear;

`ifdef IF_ADEF_CHECK_EN
    assign mis   = |pc_req_q[1:0];
    assign mis_d = |pc_req_d[1:0];
`else
    assign mis   = 1'b0;
    assign mis_d = 1'b0;
`endif

    assign track = (state_q == S_REQ && !mis) || state_q == S_WAIT;
    assign arm   = (state_q == S_REQ && !mis && inst_sram_addr_ok) || state_q == S_WAIT;
    assign clear = state_q == S_WAIT && inst_sram_data_ok;
    assign drop  = cancel | redir;

    if_redirect_pend u_pend (
        .clk            (clk),
        .rst            (rst),
        .flush_valid_i  (flush_valid),
        .flush_target_i (flush_target),
        .br_taken_i     (br_taken),
        .br_target_i    (br_target),
        .track_i        (track),
        .arm_i          (arm),
        .clear_i        (clear),
        .redir_o        (redir),
        .redir_target_o (redir_target),
        .cancel_o       (cancel),
        .final_target_o (final_target)
    );

    always_comb begin
        state_d  = state_q;
        pc_req_d = pc_req_q;
        fs_d     = fs_q;
        adef_d   = adef_q;
        case (state_q)
            S_REQ: begin
                if (mis && redir) begin
                    pc_req_d = redir_target;
                end else if (mis) begin
                    state_d = S_HOLD;
                    fs_d    = {pc_req_q, 32'h0};
                    adef_d  = 1'b1;
                end else if (inst_sram_addr_ok) begin
                    state_d                  = S_WAIT;
                    fs_d[FS_TO_DS_W-1 -: 32] = pc_req_q;
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    state_d  = drop ? S_REQ : S_HOLD;
                    pc_req_d = drop ? final_target : fs_q[FS_TO_DS_W-1 -: 32] + 32'd4;
                    if (!drop) begin
                        fs_d[31:0] = inst_sram_rdata;
                        adef_d     = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = (redir || id_allow_in) ? S_REQ : S_HOLD;
                pc_req_d = redir ? redir_target : pc_req_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_req_q <= RESET_PC;
            fs_q     <= {RESET_PC, 32'h0};
            adef_q   <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_req_q <= pc_req_d;
            fs_q     <= fs_d;
            adef_q   <= adef_d;
            req_q    <= state_d == S_REQ && !mis_d;
            valid_q  <= state_d == S_HOLD;
        end
    end

    assign inst_sram_req  = req_q;
    assign inst_sram_wr   = 1'b0;
    assign inst_sram_size = SRAM_SIZE_WORD;
    assign inst_sram_addr = pc_req_q;
    assign fs_to_ds_valid = valid_q;
    assign fs_to_ds_pc    = fs_q[FS_TO_DS_W-1 -: 32];
    assign fs_to_ds_inst  = fs_q[31:0];
    assign fs_ex_adef     = adef_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed redirect/hand-off scenarios plus randomized SRAM and redirect
// traffic checked against a fetch-stream reference model.
module tb_if_fetch_unit;
    localparam logic [31:0] RPC = 32'h1c00_0000;
    logic        clk = 1'b0, rst = 1'b1;
    logic        inst_sram_req, inst_sram_wr, fs_to_ds_valid, fs_ex_adef;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, fs_to_ds_pc, fs_to_ds_inst;
    logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0, flush_target = '0, br_target = '0;
    logic        flush_valid = 1'b0, br_taken = 1'b0, id_allow_in = 1'b0;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .flush_valid(flush_valid), .flush_target(flush_target),
        .br_taken(br_taken), .br_target(br_target), .id_allow_in(id_allow_in),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc),
        .fs_to_ds_inst(fs_to_ds_inst), .fs_ex_adef(fs_ex_adef)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'ha5c3_0f1e;
    endfunction

    function automatic logic [31:0] rtgt();
        return RPC + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        flush_valid = 1'b0; br_taken = 1'b0; id_allow_in = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic fetch(input int gap, input logic [31:0] data);
        n_vec++; if (inst_sram_req !== 1'b1) begin n_err++; $display("FAIL fetch_req: got %h exp 1", inst_sram_req); end
        inst_sram_addr_ok = 1'b1; tick; inst_sram_addr_ok = 1'b0;
        repeat (gap) tick;
        inst_sram_data_ok = 1'b1; inst_sram_rdata = data; tick; inst_sram_data_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        n_vec++; if (inst_sram_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %h exp 0", inst_sram_req); end
        n_vec++; if (inst_sram_addr !== RPC) begin n_err++; $display("FAIL rst_addr: got %h exp %h", inst_sram_addr, RPC); end
        n_vec++; if (fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %h exp 0", fs_to_ds_valid); end
        n_vec++; if (fs_to_ds_pc !== RPC) begin n_err++; $display("FAIL rst_pc: got %h exp %h", fs_to_ds_pc, RPC); end
        n_vec++; if (fs_to_ds_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h exp 0", fs_to_ds_inst); end
        n_vec++; if (fs_ex_adef !== 1'b0) begin n_err++; $display("FAIL rst_adef: got %h exp 0", fs_ex_adef); end
        n_vec++; if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'b10) begin n_err++; $display("FAIL rst_wr_size: got %h/%h exp 0/2", inst_sram_wr, inst_sram_size); end
        rst = 1'b0;
        tick;
        n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin n_err++; $display("FAIL first_req: got %h@%h exp 1@%h", inst_sram_req, inst_sram_addr, RPC); end
    endtask

    task automatic test_basic;
        do_reset;
        fetch(1, 32'h0280_0400);
        n_vec++; if (fs_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %h exp 1", fs_to_ds_valid); end
        n_vec++; if (fs_to_ds_pc !== RPC) begin n_err++; $display("FAIL basic_pc: got %h exp %h", fs_to_ds_pc, RPC); end
        n_vec++; if (fs_to_ds_inst !== 32'h0280_0400) begin n_err++; $display("FAIL basic_inst: got %h exp 02800400", fs_to_ds_inst); end
        id_allow_in = 1'b1; tick; id_allow_in = 1'b0;
        n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC + 32'd4) begin n_err++; $display("FAIL basic_next: got %h@%h exp 1@%h", inst_sram_req, inst_sram_addr, RPC + 32'd4); end
        n_vec++; if (fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %h exp 0", fs_to_ds_valid); end
    endtask

    task automatic test_branch_wait;
        do_reset;
        inst_sram_addr_ok = 1'b1; tick; inst_sram_addr_ok = 1'b0;
        br_taken = 1'b1; br_target = 32'h1c00_0100; tick; br_taken = 1'b0;
        inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdead_beef; tick; inst_sram_data_ok = 1'b0;
        n_vec++; if (fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL brw_valid: got %h exp 0", fs_to_ds_valid); end
        n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0100) begin n_err++; $display("FAIL brw_next: got %h@%h exp 1@1c000100", inst_sram_req, inst_sram_addr); end
    endtask

    task automatic test_flush_held;
        do_reset;
        flush_valid = 1'b1; flush_target = 32'h1c00_8000; tick; flush_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin n_err++; $display("FAIL flh_stable%0d: got %h@%h exp 1@%h", i, inst_sram_req, inst_sram_addr, RPC); end
            tick;
        end
        fetch(1, 32'h1234_5678);
        n_vec++; if (fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL flh_valid: got %h exp 0", fs_to_ds_valid); end
        n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_8000) begin n_err++; $display("FAIL flh_next: got %h@%h exp 1@1c008000", inst_sram_req, inst_sram_addr); end
    endtask

    task automatic test_both_redirect;
        do_reset;
        inst_sram_addr_ok = 1'b1; tick; inst_sram_addr_ok = 1'b0;
        flush_valid = 1'b1; flush_target = 32'h1c00_8000; br_taken = 1'b1; br_target = 32'h1c00_0200;
        tick; flush_valid = 1'b0; br_taken = 1'b0;
        inst_sram_data_ok = 1'b1; tick; inst_sram_data_ok = 1'b0;
        n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_8000) begin n_err++; $display("FAIL both_wait: got %h@%h exp 1@1c008000", inst_sram_req, inst_sram_addr); end
        fetch(0, 32'haaaa_5555);
        n_vec++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== 32'h1c00_8000) begin n_err++; $display("FAIL both_fetch: got %h@%h exp 1@1c008000", fs_to_ds_valid, fs_to_ds_pc); end
        flush_valid = 1'b1; flush_target = 32'h1c00_9000; br_taken = 1'b1; br_target = 32'h1c00_0200;
        tick; flush_valid = 1'b0; br_taken = 1'b0;
        n_vec++; if (fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL both_hold_valid: got %h exp 0", fs_to_ds_valid); end
        n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_9000) begin n_err++; $display("FAIL both_hold: got %h@%h exp 1@1c009000", inst_sram_req, inst_sram_addr); end
    endtask

    task automatic test_pend_priority;
        do_reset;
        flush_valid = 1'b1; flush_target = 32'h1c00_8000; tick; flush_valid = 1'b0;
        br_taken = 1'b1; br_target = 32'h1c00_0200; tick; br_taken = 1'b0;
        fetch(0, 32'h0);
        n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_8000) begin n_err++; $display("FAIL prio_flush_kept: got %h@%h exp 1@1c008000", inst_sram_req, inst_sram_addr); end
        br_taken = 1'b1; br_target = 32'h1c00_0300; tick; br_taken = 1'b0;
        flush_valid = 1'b1; flush_target = 32'h1c00_a000; tick; flush_valid = 1'b0;
        fetch(1, 32'h0);
        n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_a000) begin n_err++; $display("FAIL prio_flush_over: got %h@%h exp 1@1c00a000", inst_sram_req, inst_sram_addr); end
    endtask

    task automatic test_hold_stall;
        do_reset;
        fetch(0, 32'h1111_2222);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 3) begin
                n_vec++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== RPC || fs_to_ds_inst !== 32'h1111_2222) begin n_err++; $display("FAIL stall%0d: got %h %h %h exp 1 %h 11112222", i, fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, RPC); end
            end
            br_taken = (i == 3); br_target = 32'h1c00_0300;
            tick; br_taken = 1'b0;
            if (i == 3) begin
                n_vec++; if (fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL stall_br_valid: got %h exp 0", fs_to_ds_valid); end
                n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0300) begin n_err++; $display("FAIL stall_br_req: got %h@%h exp 1@1c000300", inst_sram_req, inst_sram_addr); end
            end
        end
    endtask

`ifdef IF_ADEF_CHECK_EN
    task automatic test_adef;
        do_reset;
        fetch(0, 32'h0);
        br_taken = 1'b1; br_target = 32'h1c00_0102; tick; br_taken = 1'b0;
        n_vec++; if (inst_sram_req !== 1'b0) begin n_err++; $display("FAIL adef_noreq: got %h exp 0", inst_sram_req); end
        tick;
        n_vec++; if (fs_to_ds_valid !== 1'b1 || fs_ex_adef !== 1'b1) begin n_err++; $display("FAIL adef_flag: got %h/%h exp 1/1", fs_to_ds_valid, fs_ex_adef); end
        n_vec++; if (fs_to_ds_pc !== 32'h1c00_0102 || fs_to_ds_inst !== 32'h0) begin n_err++; $display("FAIL adef_pc_inst: got %h/%h exp 1c000102/0", fs_to_ds_pc, fs_to_ds_inst); end
        n_vec++; if (inst_sram_req !== 1'b0) begin n_err++; $display("FAIL adef_noreq2: got %h exp 0", inst_sram_req); end
    endtask
`endif

    // Reference: ID must only ever see the instruction stream starting at the latest
    // honoured redirect target; a branch is ignored while a flush taken during an
    // in-progress fetch has not yet seen that fetch's response.
    task automatic test_random(input int cycles);
        logic        outst, sticky, hold_req, busy, redir;
        logic [31:0] oaddr, exp_pc, hold_addr;
        int          lat, handoffs;
        outst = 1'b0; sticky = 1'b0; hold_req = 1'b0; exp_pc = RPC;
        oaddr = '0; hold_addr = '0; lat = 0; handoffs = 0;
        for (int c = 0; c < cycles; c++) begin
            inst_sram_addr_ok = inst_sram_req && !outst && ($urandom_range(0, 1) == 1);
            inst_sram_data_ok = outst && lat == 0;
            inst_sram_rdata   = inst_sram_data_ok ? mem(oaddr) : $urandom;
            flush_valid  = $urandom_range(0, 31) == 0; flush_target = rtgt();
            br_taken     = $urandom_range(0, 15) == 0; br_target    = rtgt();
            id_allow_in  = $urandom_range(0, 9) < 6;
            if (hold_req) begin
                n_vec++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== hold_addr) begin n_err++; $display("FAIL rnd_req_stable c%0d: got %h@%h exp 1@%h", c, inst_sram_req, inst_sram_addr, hold_addr); end
            end
            if (outst) begin
                n_vec++; if (inst_sram_req !== 1'b0) begin n_err++; $display("FAIL rnd_one_inflight c%0d: got %h exp 0", c, inst_sram_req); end
            end
            if (fs_to_ds_valid) begin
                n_vec++; if (fs_to_ds_pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc c%0d: got %h exp %h", c, fs_to_ds_pc, exp_pc); end
                n_vec++; if (fs_to_ds_inst !== mem(fs_to_ds_pc)) begin n_err++; $display("FAIL rnd_inst c%0d: got %h exp %h", c, fs_to_ds_inst, mem(fs_to_ds_pc)); end
            end
            n_vec++; if (fs_ex_adef !== 1'b0) begin n_err++; $display("FAIL rnd_adef c%0d: got %h exp 0", c, fs_ex_adef); end
            busy  = inst_sram_req || outst;
            redir = flush_valid || br_taken;
            if (flush_valid) begin
                exp_pc = flush_target;
                sticky = busy;
            end else if (br_taken && !sticky) begin
                exp_pc = br_target;
            end
            if (!redir && fs_to_ds_valid && id_allow_in) begin
                handoffs++;
                exp_pc = exp_pc + 32'd4;
            end
            if (inst_sram_data_ok) begin
                outst  = 1'b0;
                sticky = 1'b0;
            end else if (outst) begin
                lat--;
            end
            if (inst_sram_addr_ok) begin
                outst = 1'b1; oaddr = inst_sram_addr; lat = $urandom_range(0, 3);
            end
            hold_req  = inst_sram_req && !inst_sram_addr_ok;
            hold_addr = inst_sram_addr;
            tick;
        end
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        flush_valid = 1'b0; br_taken = 1'b0; id_allow_in = 1'b0;
        n_vec++; if (handoffs < 10) begin n_err++; $display("FAIL rnd_progress: got %0d handoffs exp >= 10", handoffs); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_branch_wait;
        test_flush_held;
        test_both_redirect;
        test_pend_priority;
        test_hold_stall;
`ifdef IF_ADEF_CHECK_EN
        test_adef;
`endif
        do_reset;
        test_random(1500);
        do_reset;
        test_random(1500);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
